// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared width defaults and the all-zero bubble instruction for the fetch queue
package fetch_queue_pkg;
  localparam int PC_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam logic [INST_W_DEF-1:0] BUBBLE_INST = '0;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF/ID bundle; master drives rdy/flush/IF entry/ID stall, slave (queue) returns if_ready, head entry and count
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
);
  logic rdy_in;
  logic flush_in;
  logic if_valid_in;
  logic [PC_W-1:0] if_pc_in;
  logic [INST_W-1:0] if_inst_in;
  logic if_pred_in;
  logic if_ready_out;
  logic id_stall_in;
  logic id_valid_out;
  logic [PC_W-1:0] id_pc_out;
  logic [INST_W-1:0] id_inst_out;
  logic id_pred_out;
  logic [$clog2(DEPTH):0] count_out;
  modport master (
    output rdy_in, flush_in, if_valid_in, if_pc_in, if_inst_in, if_pred_in, id_stall_in,
    input if_ready_out, id_valid_out, id_pc_out, id_inst_out, id_pred_out, count_out
  );
  modport slave (
    input rdy_in, flush_in, if_valid_in, if_pc_in, if_inst_in, if_pred_in, id_stall_in,
    output if_ready_out, id_valid_out, id_pc_out, id_inst_out, id_pred_out, count_out
  );
endinterface

// File: rtl/fq_entry_ram.sv
// fq_entry_ram: DEPTH x W entry storage; clk_i, one write port (we_i/waddr_i/wdata_i), one async read port (raddr_i/rdata_o)
module fq_entry_ram #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID instruction FIFO; clk_in/rst_in plus bus (slave): rdy/flush, IF push side, ID head/stall side, count
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input logic          clk_in,
  input logic          rst_in,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop, valid;
  logic [EW-1:0] rd_data;
  assign valid = count_q != '0;
  assign bus.if_ready_out = count_q != CW'(DEPTH);
  assign push = bus.if_valid_in && bus.if_ready_out && !bus.flush_in && bus.rdy_in;
  assign pop = valid && !bus.id_stall_in && !bus.flush_in && bus.rdy_in;
  always_comb begin
    wr_ptr_d = bus.flush_in ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = bus.flush_in ? '0 : rd_ptr_q + AW'(pop);
    count_d = bus.flush_in ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else if (bus.rdy_in) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  fq_entry_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk_i   (clk_in),
    .we_i    (push && !rst_in),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.if_pred_in, bus.if_inst_in, bus.if_pc_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  assign bus.id_valid_out = valid;
  assign {bus.id_pred_out, bus.id_inst_out, bus.id_pc_out} = valid ? rd_data : {1'b0, INST_W'(BUBBLE_INST), PC_W'(0)};
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random stimulus checked against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic        pred;
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  logic clk = 1'b0;
  logic rst, rdy, flush, vld, pred, stall;
  logic [31:0] pc, inst;
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  fetch_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus ();
  assign bus.rdy_in = rdy;
  assign bus.flush_in = flush;
  assign bus.if_valid_in = vld;
  assign bus.if_pc_in = pc;
  assign bus.if_inst_in = inst;
  assign bus.if_pred_in = pred;
  assign bus.id_stall_in = stall;
  fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    ent_t h;
    h = q.size() != 0 ? q[0] : '0;
    chk("count", 64'(bus.count_out), 64'(q.size()));
    chk("valid", 64'(bus.id_valid_out), 64'(q.size() != 0));
    chk("ready", 64'(bus.if_ready_out), 64'(q.size() != DEPTH));
    chk("pc", 64'(bus.id_pc_out), 64'(h.pc));
    chk("inst", 64'(bus.id_inst_out), 64'(h.inst));
    chk("pred", 64'(bus.id_pred_out), 64'(h.pred));
  endtask
  task automatic step(input logic r, input logic rd, input logic fl, input logic v,
                      input logic [31:0] p, input logic [31:0] i, input logic pr, input logic st);
    logic do_push, do_pop;
    rst = r; rdy = rd; flush = fl; vld = v; pc = p; inst = i; pred = pr; stall = st;
    @(posedge clk);
    do_push = v && q.size() < DEPTH && !fl && rd;
    do_pop = q.size() > 0 && !st && !fl && rd;
    if (r) q.delete();
    else if (rd) begin
      if (fl) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{pred: pr, inst: i, pc: p});
      end
    end
    @(negedge clk);
    check_all();
  endtask
  initial begin
    @(negedge clk);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h55, 32'h66, 1, 0);
    chk("reset_ready", 64'(bus.if_ready_out), 64'd1);
    step(0, 1, 0, 1, 32'h1000, 32'h00500093, 0, 1);
    chk("first_pc", 64'(bus.id_pc_out), 64'h1000);
    chk("first_inst", 64'(bus.id_inst_out), 64'h00500093);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 32'h2000 + 32'(4 * k), 32'hA0 + 32'(k), k[0], 1);
    chk("full_count", 64'(bus.count_out), 64'd4);
    chk("full_ready", 64'(bus.if_ready_out), 64'd0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 32'h3000 + 32'(k), 32'(k), 1, 1);
    step(0, 1, 1, 1, 32'h9999, 32'h1, 1, 0);
    chk("flush_inst", 64'(bus.id_inst_out), 64'd0);
    step(0, 1, 0, 1, 32'h4000, 32'h0, 1, 1);
    step(0, 1, 0, 1, 32'h4004, 32'h11, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 32'h5000 + 32'(k), 32'h100 + 32'(k), k[1], 0);
    chk("steady_count", 64'(bus.count_out), 64'd2);
    step(0, 1, 0, 1, 32'h6000, 32'h200, 0, 1);
    step(0, 0, 1, 1, 32'h6004, 32'h201, 1, 0);
    chk("frozen_count", 64'(bus.count_out), 64'd3);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h7000, 32'h300, 1, 1);
    step(1, 0, 0, 1, 32'h7004, 32'h301, 0, 0);
    chk("rst_norddy_valid", 64'(bus.id_valid_out), 64'd0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(99) < 3, $urandom_range(99) < 85, $urandom_range(99) < 5,
           $urandom_range(99) < 65, $urandom, $urandom_range(3) == 0 ? 32'h0 : $urandom,
           1'($urandom), $urandom_range(99) < 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
